// File: rtl/mvb_rx_fsl_bridge.sv
// MVB receive buffer: decoded words plus one status word per frame, queued in a
// FWFT FIFO and presented to the MicroBlaze as an FSL slave stream.
module mvb_rx_fsl_bridge #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       word_in,
  input  logic              word_valid,
  input  logic              frame_over,
  input  logic              length_error,
  input  logic              signal_error,
  input  logic              delimiter_error,
  input  logic              quality_error,
  input  logic              crc_error,
  input  logic              fsl_s_read,
  output logic [31:0]       fsl_s_data,
  output logic              fsl_s_control,
  output logic              fsl_s_exists,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [7:0]        lost_frames
);

  typedef enum logic [1:0] {IDLE, RECV, STAT} state_t;

  state_t            r_state, w_state_nxt;
  logic [16:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [4:0]        r_wc, w_wc_nxt;
  logic              r_drop, w_drop_nxt;
  logic [4:0]        r_err, w_err_nxt;
  logic              r_overflow;
  logic [7:0]        r_lost;

  logic [ADDR_W:0]   w_free, w_free_w;
  logic              w_stat_push, w_stat_drop, w_word_push, w_word_drop, w_pop;
  logic [15:0]       w_status;
  logic [ADDR_W-1:0] w_word_addr;

  // A status write and a new-frame word can land in the same STAT cycle; the
  // status goes first and the word must still leave room for its own status.
  assign w_free      = (ADDR_W+1)'(DEPTH) - r_count;
  assign w_stat_push = (r_state == STAT) && (w_free != '0);
  assign w_stat_drop = (r_state == STAT) && (w_free == '0);
  assign w_free_w    = w_free - {{ADDR_W{1'b0}}, w_stat_push};
  assign w_word_push = word_valid && (w_free_w >= (ADDR_W+1)'(2));
  assign w_word_drop = word_valid && !w_word_push;
  assign w_pop       = fsl_s_read && (r_count != '0);
  assign w_status    = {5'b0, r_drop, r_err, r_wc};
  assign w_word_addr = r_wr_ptr + {{(ADDR_W-1){1'b0}}, w_stat_push};

  always_comb begin
    w_state_nxt = r_state;
    w_wc_nxt    = r_wc;
    w_drop_nxt  = r_drop;
    w_err_nxt   = r_err;
    if (r_state == STAT) begin
      w_state_nxt = IDLE;
      w_wc_nxt    = '0;
      w_drop_nxt  = 1'b0;
      w_err_nxt   = '0;
    end
    if (word_valid) begin
      w_state_nxt = RECV;
      if (r_state == RECV) begin
        w_wc_nxt   = (r_wc == 5'd31) ? 5'd31 : r_wc + 5'd1;
        w_drop_nxt = r_drop | w_word_drop;
      end else begin
        w_wc_nxt   = 5'd1;
        w_drop_nxt = w_word_drop;
      end
    end
    if (frame_over) begin
      w_state_nxt = STAT;
      w_err_nxt   = {length_error, signal_error, delimiter_error, quality_error, crc_error};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wc       <= '0;
      r_drop     <= 1'b0;
      r_err      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_lost     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wc     <= w_wc_nxt;
      r_drop   <= w_drop_nxt;
      r_err    <= w_err_nxt;
      r_wr_ptr <= r_wr_ptr + ADDR_W'(w_stat_push) + ADDR_W'(w_word_push);
      r_rd_ptr <= r_rd_ptr + ADDR_W'(w_pop);
      r_count  <= r_count + (ADDR_W+1)'(w_stat_push) + (ADDR_W+1)'(w_word_push)
                  - (ADDR_W+1)'(w_pop);
      if (overflow_clr) begin
        r_overflow <= 1'b0;
        r_lost     <= '0;
      end else begin
        if (w_word_drop || w_stat_drop) r_overflow <= 1'b1;
        if (w_stat_drop && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
      end
    end
  end

  // Storage needs no reset: the read side is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_stat_push) r_mem[r_wr_ptr]    <= {1'b1, w_status};
    if (w_word_push) r_mem[w_word_addr] <= {1'b0, word_in};
  end

  assign fsl_s_exists  = (r_count != '0);
  assign fsl_s_data    = fsl_s_exists ? {16'h0, r_mem[r_rd_ptr][15:0]} : 32'h0;
  assign fsl_s_control = fsl_s_exists & r_mem[r_rd_ptr][16];
  assign fifo_count    = r_count;
  assign overflow      = r_overflow;
  assign lost_frames   = r_lost;

endmodule

// File: tb/tb_mvb_rx_fsl_bridge.sv
// Directed bench for mvb_rx_fsl_bridge: hand-computed FIFO contents and flags.
module tb_mvb_rx_fsl_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0, frame_over = 1'b0;
  logic        length_error = 1'b0, signal_error = 1'b0, delimiter_error = 1'b0;
  logic        quality_error = 1'b0, crc_error = 1'b0;
  logic        fsl_s_read = 1'b0, overflow_clr = 1'b0;
  logic [31:0] fsl_s_data;
  logic        fsl_s_control, fsl_s_exists, overflow;
  logic [5:0]  fifo_count;
  logic [7:0]  lost_frames;

  int n_chk = 0;
  int n_fail = 0;

  mvb_rx_fsl_bridge #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .frame_over(frame_over), .length_error(length_error), .signal_error(signal_error),
    .delimiter_error(delimiter_error), .quality_error(quality_error),
    .crc_error(crc_error), .fsl_s_read(fsl_s_read), .fsl_s_data(fsl_s_data),
    .fsl_s_control(fsl_s_control), .fsl_s_exists(fsl_s_exists),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
    .lost_frames(lost_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    word_in = w; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic frame_end(input logic crc);
    frame_over = 1'b1; crc_error = crc;
    tick();
    frame_over = 1'b0; crc_error = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] d, input logic c);
    chk({tag, ".data"}, fsl_s_data, {16'h0, d});
    chk({tag, ".ctrl"}, {31'h0, fsl_s_control}, {31'h0, c});
    fsl_s_read = 1'b1;
    tick();
    fsl_s_read = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".exists"}, {31'h0, fsl_s_exists}, 32'h0);
    chk({tag, ".data"}, fsl_s_data, 32'h0);
    chk({tag, ".ctrl"}, {31'h0, fsl_s_control}, 32'h0);
    chk({tag, ".count"}, {26'h0, fifo_count}, 32'h0);
    chk({tag, ".ovf"}, {31'h0, overflow}, 32'h0);
    chk({tag, ".lost"}, {24'h0, lost_frames}, 32'h0);
  endtask

  initial begin
    // 1: reset state, then a clean 3-word frame
    #12;
    chk_zero("reset");
    rst = 1'b1;
    tick();
    send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
    chk("t1.count3", {26'h0, fifo_count}, 32'd3);
    frame_end(1'b0);
    tick();
    chk("t1.count4", {26'h0, fifo_count}, 32'd4);
    pop_chk("t1.w0", 16'h1111, 1'b0);
    pop_chk("t1.w1", 16'h2222, 1'b0);
    pop_chk("t1.w2", 16'h3333, 1'b0);
    pop_chk("t1.st", 16'h0003, 1'b1);
    chk("t1.empty", {31'h0, fsl_s_exists}, 32'h0);

    // 2: empty frame with CRC error
    frame_end(1'b1);
    tick();
    chk("t2.count", {26'h0, fifo_count}, 32'd1);
    pop_chk("t2.st", 16'h0020, 1'b1);
    chk("t2.empty", {31'h0, fsl_s_exists}, 32'h0);

    // 3: 40-word frame, no reads
    for (int i = 0; i < 40; i++) send_word(16'h0100 + 16'(i));
    frame_end(1'b0);
    tick();
    chk("t3.count", {26'h0, fifo_count}, 32'd32);
    chk("t3.ovf", {31'h0, overflow}, 32'h1);
    chk("t3.head", fsl_s_data, 32'h0100);

    // 4: frame into a full FIFO loses its status
    send_word(16'hDEAD); send_word(16'hBEEF);
    frame_end(1'b0);
    tick();
    chk("t4.lost", {24'h0, lost_frames}, 32'd1);
    chk("t4.count", {26'h0, fifo_count}, 32'd32);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t4.ovf_clr", {31'h0, overflow}, 32'h0);
    chk("t4.lost_clr", {24'h0, lost_frames}, 32'h0);
    for (int i = 0; i < 31; i++) pop_chk("t3.drain", 16'h0100 + 16'(i), 1'b0);
    pop_chk("t3.st", 16'h041F, 1'b1);
    chk("t3.empty", {31'h0, fsl_s_exists}, 32'h0);

    // 5: last word coincident with frame_over; push+pop at count 5
    send_word(16'hA001); send_word(16'hA002);
    word_in = 16'hA003; word_valid = 1'b1; frame_over = 1'b1;
    tick();
    word_valid = 1'b0; frame_over = 1'b0;
    chk("t5.word_first", {26'h0, fifo_count}, 32'd3);
    tick();
    chk("t5.stat_next", {26'h0, fifo_count}, 32'd4);
    pop_chk("t5.w0", 16'hA001, 1'b0);
    pop_chk("t5.w1", 16'hA002, 1'b0);
    pop_chk("t5.w2", 16'hA003, 1'b0);
    pop_chk("t5.st", 16'h0003, 1'b1);
    for (int i = 0; i < 5; i++) send_word(16'hB000 + 16'(i));
    chk("t5.count5", {26'h0, fifo_count}, 32'd5);
    word_in = 16'hB005; word_valid = 1'b1; fsl_s_read = 1'b1;
    tick();
    word_valid = 1'b0; fsl_s_read = 1'b0;
    chk("t5.pushpop", {26'h0, fifo_count}, 32'd5);
    frame_end(1'b0);
    tick();
    for (int i = 1; i < 6; i++) pop_chk("t5.b", 16'hB000 + 16'(i), 1'b0);
    pop_chk("t5.st6", 16'h0006, 1'b1);

    // 6: reset mid-frame, then a 1-word frame
    send_word(16'hC001); send_word(16'hC002);
    rst = 1'b0;
    #2;
    chk_zero("t6.rst");
    tick();
    rst = 1'b1;
    tick();
    send_word(16'hBEEF);
    frame_end(1'b0);
    tick();
    chk("t6.count", {26'h0, fifo_count}, 32'd2);
    pop_chk("t6.w", 16'hBEEF, 1'b0);
    pop_chk("t6.st", 16'h0001, 1'b1);
    chk("t6.empty", {31'h0, fsl_s_exists}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
